// File: rtl/gray_to_bin_rx.sv
// Receive side of a Gray-coded link: synchronizes an asynchronous Gray word, decodes it
// to binary and tracks it, classifying each change as +1, -1 or an illegal jump.
//
// state | meaning
// ------+-----------------------------------------------------------------
// FILL  | after reset, waits SYNC_STAGES+1 cycles for the sync chain to fill
// IDLE  | tracking disabled; b_out still follows the input, no pulses
// ACQ   | takes the current decoded value as the reference, no step check
// TRACK | locked; every change is checked as +1, -1 or illegal jump

module gray_to_bin_rx #(
  parameter int W           = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] g_in,
  output logic [W-1:0] b_out,
  output logic         b_vld,
  output logic         inc,
  output logic         dec,
  output logic         err,
  output logic [7:0]   err_cnt,
  output logic         locked
);

  localparam int CW = $clog2(SYNC_STAGES + 1);

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    IDLE  = 2'd1,
    ACQ   = 2'd2,
    TRACK = 2'd3
  } state_t;

  state_t         state, state_nx;
  logic [CW-1:0]  fill_cnt;
  logic [W-1:0]   sync_q [SYNC_STAGES];
  logic [W-1:0]   gs;
  logic [W-1:0]   bn;
  logic [W-1:0]   diff;
  logic           step_chk;
  logic           step_up;
  logic           step_dn;
  logic           jump;
  logic           inc_nx;
  logic           dec_nx;
  logic           err_nx;

  // Synchronizer runs regardless of en so the chain is always current.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= g_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign gs = sync_q[SYNC_STAGES-1];

  // Binary bit i is the XOR of Gray bits i..W-1.
  always_comb begin
    bn = '0;
    for (int i = 0; i < W; i++) begin
      bn[i] = ^(gs >> i);
    end
  end

  assign diff     = bn - b_out;
  assign step_chk = en && (state == TRACK);
  assign step_up  = (diff == W'(1));
  assign step_dn  = (diff == {W{1'b1}});
  assign jump     = (diff != '0) && !step_up && !step_dn;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FILL;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    inc_nx   = 1'b0;
    dec_nx   = 1'b0;
    err_nx   = 1'b0;
    case (state)
      FILL: begin
        if (fill_cnt == '0) begin
          state_nx = en ? ACQ : IDLE;
        end
      end
      IDLE: begin
        if (en) begin
          state_nx = ACQ;
        end
      end
      ACQ: begin
        state_nx = en ? TRACK : IDLE;
      end
      TRACK: begin
        if (!en) begin
          state_nx = IDLE;
        end else if (jump) begin
          state_nx = ACQ;
        end
      end
      default: state_nx = FILL;
    endcase
    if (step_chk) begin
      inc_nx = step_up;
      dec_nx = step_dn;
      err_nx = jump;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fill_cnt <= CW'(SYNC_STAGES);
      b_out    <= '0;
      inc      <= 1'b0;
      dec      <= 1'b0;
      err      <= 1'b0;
      err_cnt  <= 8'd0;
    end else begin
      if (state == FILL && fill_cnt != '0) begin
        fill_cnt <= fill_cnt - CW'(1);
      end
      if (state != FILL) begin
        b_out <= bn;
      end
      inc <= inc_nx;
      dec <= dec_nx;
      err <= err_nx;
      if (err_nx && err_cnt != 8'hFF) begin
        err_cnt <= err_cnt + 8'd1;
      end
    end
  end

  assign b_vld  = (state == ACQ) || (state == TRACK);
  assign locked = (state == TRACK);

endmodule

// File: tb/tb_gray_to_bin_rx.sv
// Directed bench for gray_to_bin_rx: reset/fill, up-count wrap, down step, illegal jumps,
// error-count saturation and enable gating.

module tb_gray_to_bin_rx;

  logic       clk;
  logic       rst;
  logic       en;
  logic [3:0] g_in;
  logic [3:0] b_out;
  logic       b_vld;
  logic       inc;
  logic       dec;
  logic       err;
  logic [7:0] err_cnt;
  logic       locked;

  int total = 0;
  int bad   = 0;
  int n_inc = 0;
  int n_dec = 0;
  int n_err = 0;
  int n_multi = 0;
  int s_inc, s_dec, s_err;

  gray_to_bin_rx #(.W(4), .SYNC_STAGES(2)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .g_in    (g_in),
    .b_out   (b_out),
    .b_vld   (b_vld),
    .inc     (inc),
    .dec     (dec),
    .err     (err),
    .err_cnt (err_cnt),
    .locked  (locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulses last one cycle, so sampling on the falling edge counts each once.
  always @(negedge clk) begin
    if (inc === 1'b1) n_inc++;
    if (dec === 1'b1) n_dec++;
    if (err === 1'b1) n_err++;
    if (int'(inc) + int'(dec) + int'(err) > 1) n_multi++;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] gray(input int v);
    logic [3:0] b;
    b = v[3:0];
    return b ^ (b >> 1);
  endfunction

  task automatic snap();
    s_inc = n_inc;
    s_dec = n_dec;
    s_err = n_err;
  endtask

  initial begin
    rst  = 1'b1;
    en   = 1'b0;
    g_in = 4'b0000;
    step(2);
    check("rst_b_out", b_out, 0);
    check("rst_b_vld", b_vld, 0);
    check("rst_locked", locked, 0);
    check("rst_err_cnt", err_cnt, 0);
    check("rst_pulses", {inc, dec, err}, 0);

    rst = 1'b0;
    en  = 1'b1;
    step(1);
    check("fill_vld_1", b_vld, 0);
    step(1);
    check("fill_vld_2", b_vld, 0);
    step(1);
    check("acq_vld", b_vld, 1);
    check("acq_locked", locked, 0);
    step(1);
    check("track_locked", locked, 1);
    check("track_b_out", b_out, 0);

    // Up-count through all 16 codes, ending with 1000 -> 0000.
    snap();
    for (int v = 1; v <= 16; v++) begin
      g_in = gray(v);
      step(4);
      check("up_b_out", b_out, v % 16);
    end
    check("up_inc_cnt", n_inc - s_inc, 16);
    check("up_dec_cnt", n_dec - s_dec, 0);
    check("up_err_cnt", n_err - s_err, 0);
    check("up_err_reg", err_cnt, 0);
    check("up_g_last", g_in, 4'b0000);

    // 0 -> 15 is a single down step.
    snap();
    g_in = 4'b1000;
    for (int i = 0; i < 4; i++) begin
      step(1);
      check("dn_locked", locked, 1);
    end
    check("dn_b_out", b_out, 15);
    check("dn_dec_cnt", n_dec - s_dec, 1);
    check("dn_err_cnt", n_err - s_err, 0);

    // Walk 15 -> 0 -> 1 by legal steps, then jump 1 -> 3.
    g_in = 4'b0000;
    step(4);
    g_in = 4'b0001;
    step(4);
    check("pre_jump_b_out", b_out, 1);
    snap();
    g_in = 4'b0010;
    step(2);
    check("jump_locked_before", locked, 1);
    step(1);
    check("jump_err", err, 1);
    check("jump_locked_low", locked, 0);
    check("jump_b_out", b_out, 3);
    check("jump_err_reg", err_cnt, 1);
    step(1);
    check("jump_relock", locked, 1);
    check("jump_err_clear", err, 0);
    check("jump_no_inc", n_inc - s_inc, 0);

    // 300 more illegal jumps alternating between binary 3 and 0.
    snap();
    for (int i = 0; i < 300; i++) begin
      g_in = (i % 2 == 0) ? 4'b0000 : 4'b0010;
      step(5);
      if (i == 253) check("sat_cnt_255", err_cnt, 255);
    end
    check("sat_err_reg", err_cnt, 255);
    g_in = 4'b0000;
    step(5);
    check("sat_hold", err_cnt, 255);
    check("sat_err_pulses", n_err - s_err, 301);
    check("sat_locked", locked, 1);

    // Bring the value to binary 2, then disable and jump to binary 8.
    g_in = 4'b0001;
    step(4);
    g_in = 4'b0011;
    step(4);
    check("gate_pre_b_out", b_out, 2);
    check("gate_pre_locked", locked, 1);
    snap();
    en   = 1'b0;
    g_in = 4'b1100;
    for (int i = 0; i < 6; i++) begin
      step(1);
      check("gate_vld_low", b_vld, 0);
    end
    check("gate_idle_b_out", b_out, 8);
    en = 1'b1;
    step(1);
    check("gate_acq_vld", b_vld, 1);
    check("gate_acq_locked", locked, 0);
    step(1);
    check("gate_track_locked", locked, 1);
    check("gate_b_out", b_out, 8);
    check("gate_no_pulses", (n_inc - s_inc) + (n_dec - s_dec) + (n_err - s_err), 0);
    check("gate_err_reg", err_cnt, 255);

    rst = 1'b1;
    step(1);
    check("rerst_err_cnt", err_cnt, 0);
    check("rerst_b_out", b_out, 0);
    check("rerst_b_vld", b_vld, 0);
    rst = 1'b0;
    step(1);

    check("pulse_exclusive", n_multi, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
